// File: rtl/id_exe_reg_pkg.sv
// Shared widths and EXE command encodings for the ID/EXE pipeline register.
package id_exe_reg_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned EXE_CMD_W    = 4;
  localparam int unsigned REG_IDX_W    = 4;
  localparam int unsigned SHIFT_OP_W   = 12;
  localparam int unsigned SIMM_W       = 24;
  localparam int unsigned SR_W         = 4;
  localparam int unsigned BUBBLE_CNT_W = 16;

  // ALU command encodings; NOP sits on an otherwise unused code
  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001,
    EXE_NOP = 4'b1111
  } exe_cmd_e;

  localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = EXE_NOP;

  // Saturating increment for the bubble counter
  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : BUBBLE_CNT_W'(cnt + BUBBLE_CNT_W'(1));
  endfunction

endpackage

// File: rtl/id_exe_reg_pipe_field.sv
// One pipeline field: async reset, hold enable and optional clear-to-constant.
module pipe_field #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0,
  parameter bit           USE_CLR = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_hold,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold wins over clear; datapath instances tie USE_CLR low and always load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (!i_hold) begin
      if (USE_CLR && i_clr) r_q <= CLR_VAL;
      else                  r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush/bubble kill and bubble counter.
module id_exe_reg
  import id_exe_reg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    bubble,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [DATA_W-1:0]       val_rn_in,
  input  logic [DATA_W-1:0]       val_rm_in,
  input  logic [SHIFT_OP_W-1:0]   shift_operand_in,
  input  logic                    imm_in,
  input  logic [SIMM_W-1:0]       signed_imm_24_in,
  input  logic [REG_IDX_W-1:0]    dest_in,
  input  logic [EXE_CMD_W-1:0]    exe_cmd_in,
  input  logic                    wb_en_in,
  input  logic                    mem_r_en_in,
  input  logic                    mem_w_en_in,
  input  logic                    b_in,
  input  logic                    s_in,
  input  logic [SR_W-1:0]         sr_in,
  input  logic [REG_IDX_W-1:0]    src1_in,
  input  logic [REG_IDX_W-1:0]    src2_in,
  output logic [DATA_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       val_rn_out,
  output logic [DATA_W-1:0]       val_rm_out,
  output logic [SHIFT_OP_W-1:0]   shift_operand_out,
  output logic                    imm_out,
  output logic [SIMM_W-1:0]       signed_imm_24_out,
  output logic [REG_IDX_W-1:0]    dest_out,
  output logic [EXE_CMD_W-1:0]    exe_cmd_out,
  output logic                    wb_en_out,
  output logic                    mem_r_en_out,
  output logic                    mem_w_en_out,
  output logic                    b_out,
  output logic                    s_out,
  output logic [SR_W-1:0]         sr_out,
  output logic [REG_IDX_W-1:0]    src1_out,
  output logic [REG_IDX_W-1:0]    src2_out,
  output logic                    valid_out,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  logic                    w_hold;
  logic                    w_kill;
  logic                    w_bubble_only;
  logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

  assign w_hold        = freeze;
  assign w_kill        = flush | bubble;
  assign w_bubble_only = bubble & ~flush;

  // Datapath fields: reload even on a kill, never cleared
  pipe_field #(.W(DATA_W)) u_pc (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(pc_in), .o_q(pc_out));
  pipe_field #(.W(DATA_W)) u_val_rn (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(val_rn_in), .o_q(val_rn_out));
  pipe_field #(.W(DATA_W)) u_val_rm (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(val_rm_in), .o_q(val_rm_out));
  pipe_field #(.W(SHIFT_OP_W)) u_shift_operand (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill),
    .i_d(shift_operand_in), .o_q(shift_operand_out));
  pipe_field #(.W(1)) u_imm (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(imm_in), .o_q(imm_out));
  pipe_field #(.W(SIMM_W)) u_signed_imm_24 (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill),
    .i_d(signed_imm_24_in), .o_q(signed_imm_24_out));
  pipe_field #(.W(REG_IDX_W)) u_dest (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(dest_in), .o_q(dest_out));
  pipe_field #(.W(SR_W)) u_sr (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(sr_in), .o_q(sr_out));
  pipe_field #(.W(REG_IDX_W)) u_src1 (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(src1_in), .o_q(src1_out));
  pipe_field #(.W(REG_IDX_W)) u_src2 (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(src2_in), .o_q(src2_out));

  // Control fields: a kill turns the slot into a NOP
  pipe_field #(.W(EXE_CMD_W), .RST_VAL(EXE_CMD_NOP), .CLR_VAL(EXE_CMD_NOP), .USE_CLR(1'b1)) u_exe_cmd (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(exe_cmd_in), .o_q(exe_cmd_out));
  pipe_field #(.W(1), .USE_CLR(1'b1)) u_wb_en (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(wb_en_in), .o_q(wb_en_out));
  pipe_field #(.W(1), .USE_CLR(1'b1)) u_mem_r_en (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(mem_r_en_in), .o_q(mem_r_en_out));
  pipe_field #(.W(1), .USE_CLR(1'b1)) u_mem_w_en (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(mem_w_en_in), .o_q(mem_w_en_out));
  pipe_field #(.W(1), .USE_CLR(1'b1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(b_in), .o_q(b_out));
  pipe_field #(.W(1), .USE_CLR(1'b1)) u_s (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(s_in), .o_q(s_out));
  pipe_field #(.W(1), .USE_CLR(1'b1)) u_valid (
    .i_clk(clk), .i_rst(rst), .i_hold(w_hold), .i_clr(w_kill), .i_d(1'b1), .o_q(valid_out));

  // Count NOPs inserted by the hazard unit alone; a concurrent flush takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!freeze && w_bubble_only) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have freeze, input, 1, global stall: hold all state.
REQ-004 SHALL have flush, input, 1, branch taken in EXE: kill the ID instruction.
REQ-005 SHALL have bubble, input, 1, hazard unit request: insert a NOP.
REQ-006 SHALL have the ID-side inputs:
- pc_in, 32
- val_rn_in, 32
- val_rm_in, 32
- shift_operand_in, 12
- imm_in, 1
- signed_imm_24_in, 24
- dest_in, 4
- exe_cmd_in, 4
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, 1 each
- sr_in, 4
- src1_in, src2_in, 4 each
REQ-007 SHALL have one registered output per input above, with the suffix _out.
REQ-008 SHALL have valid_out, output, 1, the EXE slot holds a real instruction.
REQ-009 SHALL have bubble_cnt, output, 16, saturating count of NOPs inserted.

Function
REQ-010 Next-state priority per clk edge SHALL be: freeze > flush > bubble > load.
REQ-011 Hold (freeze=1): all outputs, including valid_out and bubble_cnt, SHALL keep their values.
REQ-012 Kill (flush=1 or bubble=1, freeze=0) SHALL:
- clear wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out and valid_out;
- set exe_cmd_out to the package NOP code;
- leave datapath fields unspecified, but still load them.
REQ-013 Load SHALL capture every _in to its _out and set valid_out=1, with a latency of exactly 1 cycle.
REQ-014 bubble_cnt SHALL increment by 1 on each kill edge caused by bubble=1 alone, and SHALL saturate at 16'hFFFF.
REQ-015 flush and bubble asserted together SHALL count as a flush, with no bubble_cnt increment.
REQ-016 The registered mem_r_en_out and mem_w_en_out SHALL be the sole source of the downstream Val2 mem select (mem_r_en_out | mem_w_en_out).
REQ-017 shift_operand_out, imm_out and val_rm_out SHALL be stable for the whole cycle following the load edge.
REQ-018 No output SHALL depend combinationally on any input.
REQ-019 Back-to-back loads SHALL sustain 1 instruction per cycle with no gap.
REQ-020 A freeze released in the same cycle that flush rises SHALL apply the flush on that edge.

Reset
REQ-021 rst=1 SHALL immediately clear every output to 0, except exe_cmd_out, which SHALL take the NOP code.
REQ-022 Reset state SHALL be valid_out=0 and bubble_cnt=0.
REQ-023 Reset mid-freeze or mid-flush SHALL override both.
REQ-024 The first edge after rst falls SHALL follow REQ-010.

Structure
REQ-025 A shared package SHALL hold:
- EXE_CMD width and encodings, including NOP;
- register-index width 4;
- shift_operand width 12;
- the bubble_cnt width.
REQ-026 One sub-module, pipe_field, SHALL be used per field: a parameterised width register with async reset, hold enable and clear-to-constant.
REQ-027 Control fields SHALL use the clear path.
REQ-028 Datapath fields SHALL ignore the clear path.

Verification
REQ-029 Scenario, reset: assert rst with arbitrary inputs -> all outputs 0, exe_cmd_out=NOP, valid_out=0, bubble_cnt=0, with no clock edge needed.
REQ-030 Scenario, load: load shift_operand_in=12'h0E3, imm_in=1, mem_r_en_in=1, val_rm_in=32'hDEADBEEF -> all four appear after 1 edge, valid_out=1.
REQ-031 Scenario, freeze: freeze=1 for 3 cycles while inputs change -> outputs unchanged; release -> new inputs after 1 edge.
REQ-032 Scenario, flush vs bubble: flush=1 and bubble=1 with wb_en_in=1 -> wb_en_out=0, valid_out=0, bubble_cnt unchanged.
REQ-033 Scenario, bubble alone: bubble alone for 2 edges -> bubble_cnt=2; preload 16'hFFFE, then 3 bubbles -> stays at 16'hFFFF.
REQ-034 Scenario, priority: freeze=1 with flush=1 -> hold; next cycle freeze=0 with flush=1 -> kill applied.
